intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_intr_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl -- eight-input prioritised interrupt controller
//
// Purpose:
//   Collects eight device request lines into a PEND register. Each line is
//   either edge-triggered (sticky, write-1-to-clear) or level-sensitive
//   (PEND tracks the line every clock), as selected by EDGE. Lines enabled by
//   MASK raise a registered intr to the CPU. The CPU acknowledges with inta.
//   At that point the lowest-numbered active line is latched as the in-service
//   vector, and the controller stays busy until software writes EOI.
//   There is no nesting. Requests that arrive during service stay pending.
//
// Ports:
//   clk     in   1  single clock, rising edge
//   clrn    in   1  asynchronous active-low reset
//   irq     in   8  device request lines, bit 0 highest priority
//   intr    out  1  registered interrupt request to the CPU
//   inta    in   1  interrupt acknowledge pulse from the CPU
//   addr    in   2  register select: 0 PEND, 1 MASK, 2 EDGE, 3 VEC/EOI
//   we      in   1  register write strobe
//   wdata   in  32  write data, bits [7:0] used
//   rdata   out 32  combinational read of the selected register
//   vector  out  3  ID of the interrupt in service
//   busy    out  1  high while an interrupt is in service
// -----------------------------------------------------------------------------
module intr_ctrl #(
  parameter logic [7:0] RESET_MASK = 8'h00,
  parameter logic [7:0] RESET_EDGE = 8'h00
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [7:0]  irq,
  output logic        intr,
  input  logic        inta,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [2:0]  vector,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  state_t      state_reg, state_next;

  logic [7:0]  irq_d_reg;
  logic [7:0]  pend_reg, pend_next;
  logic [7:0]  mask_reg;
  logic [7:0]  edge_reg;
  logic [2:0]  vector_reg, vector_next;
  logic        intr_reg, intr_next;
  logic        busy_reg, busy_next;

  logic        wr_pend, wr_mask, wr_edge, wr_eoi;
  logic [7:0]  act;
  logic        act_any;
  logic [2:0]  act_idx;
  logic        ack;
  logic [7:0]  ack_bit;
  logic [7:0]  rise;

  // Only the low byte of the write bus carries register data.
  logic        unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  assign wr_pend = we && (addr == 2'd0);
  assign wr_mask = we && (addr == 2'd1);
  assign wr_edge = we && (addr == 2'd2);
  assign wr_eoi  = we && (addr == 2'd3);

  // Active requests are taken from this cycle's registers. A MASK write that
  // coincides with inta therefore does not affect which line is acknowledged.
  assign act     = pend_reg & mask_reg;
  assign act_any = |act;

  // Priority encoder: the lowest set index wins. Scan from the top so that the
  // last assignment is the lowest set bit.
  always_comb begin
    act_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) act_idx = 3'(i);
    end
  end

  // The acknowledge is accepted only in REQ while something is still active.
  // If inta arrives with act=0, the request has gone away and the FSM returns
  // to IDLE instead.
  assign ack = (state_reg == ST_REQ) && inta && act_any;

  // ---------------------------------------------------------------------------
  // Per-line pending logic
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pend
      assign rise[gi]    = irq[gi] & ~irq_d_reg[gi];
      assign ack_bit[gi] = ack && (act_idx == 3'(gi));
      // Edge mode is sticky and is cleared by write-1-to-clear or by the
      // acknowledge. A fresh rising edge in the same cycle takes priority, so
      // that edge is not lost. Level mode just registers the line.
      assign pend_next[gi] = edge_reg[gi]
                           ? (rise[gi] | (pend_reg[gi]
                                          & ~(wr_pend & wdata[gi])
                                          & ~ack_bit[gi]))
                           : irq[gi];
    end
  endgenerate

  // The mode used for the PEND update is the EDGE value before any write in
  // this cycle. A write to EDGE therefore leaves PEND's behaviour unchanged
  // until the next cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      irq_d_reg <= 8'h00;
      pend_reg  <= 8'h00;
      mask_reg  <= RESET_MASK;
      edge_reg  <= RESET_EDGE;
    end else begin
      irq_d_reg <= irq;
      pend_reg  <= pend_next;
      if (wr_mask) mask_reg <= wdata[7:0];
      if (wr_edge) edge_reg <= wdata[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (act_any) state_next = ST_REQ;
      end
      ST_REQ: begin
        // A withdrawn or masked request has priority over inta.
        if (!act_any)  state_next = ST_IDLE;
        else if (inta) state_next = ST_SERV;
      end
      ST_SERV: begin
        if (wr_eoi) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // intr and busy are decoded from the next state and then registered. This
  // keeps them glitch-free and exactly aligned with the state register.
  // ---------------------------------------------------------------------------
  always_comb begin
    intr_next   = (state_next == ST_REQ);
    busy_next   = (state_next == ST_SERV);
    vector_next = vector_reg;
    if (ack) vector_next = act_idx;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      intr_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      vector_reg <= 3'd0;
    end else begin
      intr_reg   <= intr_next;
      busy_reg   <= busy_next;
      vector_reg <= vector_next;
    end
  end

  assign intr   = intr_reg;
  assign busy   = busy_reg;
  assign vector = vector_reg;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = 32'h0;
    case (addr)
      2'd0: rdata = {24'h0, pend_reg};
      2'd1: rdata = {24'h0, mask_reg};
      2'd2: rdata = {24'h0, edge_reg};
      2'd3: rdata = {28'h0, busy_reg, vector_reg};
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_ctrl -- scoreboard bench for intr_ctrl
//
// The stimulus process pushes hand-computed expected outputs into a queue.
// A monitor pops one entry on each falling clock edge at which an entry is
// present, and compares intr, busy, vector and rdata.
// -----------------------------------------------------------------------------
module tb_intr_ctrl;

  logic        clk;
  logic        clrn;
  logic [7:0]  irq;
  logic        intr;
  logic        inta;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [2:0]  vector;
  logic        busy;

  localparam logic [7:0] RST_MASK = 8'h11;

  intr_ctrl #(
    .RESET_MASK(RST_MASK),
    .RESET_EDGE(8'h00)
  ) dut (
    .clk    (clk),
    .clrn   (clrn),
    .irq    (irq),
    .intr   (intr),
    .inta   (inta),
    .addr   (addr),
    .we     (we),
    .wdata  (wdata),
    .rdata  (rdata),
    .vector (vector),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ei;
    logic        eb;
    logic [2:0]  ev;
    logic [1:0]  a;
    logic [31:0] er;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: compares one queued expectation per falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total += 4;
      if (intr !== e.ei) begin
        bad++;
        $display("FAIL %s.intr got=%0b want=%0b", e.name, intr, e.ei);
      end
      if (busy !== e.eb) begin
        bad++;
        $display("FAIL %s.busy got=%0b want=%0b", e.name, busy, e.eb);
      end
      if (vector !== e.ev) begin
        bad++;
        $display("FAIL %s.vector got=%0d want=%0d", e.name, vector, e.ev);
      end
      if (rdata !== e.er) begin
        bad++;
        $display("FAIL %s.rdata[a%0d] got=%h want=%h", e.name, e.a, rdata, e.er);
      end
      $display("chk %-14s intr=%0b busy=%0b vec=%0d rdata[a%0d]=%h",
               e.name, intr, busy, vector, e.a, rdata);
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    wdata = {24'h0, d};
    we    = 1'b1;
    tick();
    we    = 1'b0;
    wdata = 32'h0;
  endtask

  task automatic pulse_inta();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  // Queue an expectation for the current state, reading register a.
  task automatic chk(input string n, input logic ei, input logic eb,
                     input logic [2:0] ev, input logic [1:0] a,
                     input logic [31:0] er);
    exp_t e;
    addr = a;
    e.name = n; e.ei = ei; e.eb = eb; e.ev = ev; e.a = a; e.er = er;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b1; irq = 8'h00; inta = 1'b0; addr = 2'd0; we = 1'b0; wdata = 32'h0;
    #2 clrn = 1'b0;
    tick(); tick();
    chk("reset",      1'b0, 1'b0, 3'd0, 2'd1, {24'h0, RST_MASK});
    chk("reset_pend", 1'b0, 1'b0, 3'd0, 2'd0, 32'h0);
    clrn = 1'b1;
    tick();

    // Level-mode request, acknowledge, and EOI with the line still high.
    wr(2'd1, 8'h04);
    irq = 8'h04;
    tick();
    chk("lvl_pend",    1'b0, 1'b0, 3'd0, 2'd0, 32'h04);
    tick();
    chk("lvl_intr",    1'b1, 1'b0, 3'd0, 2'd3, 32'h0);
    pulse_inta();
    chk("lvl_serv",    1'b0, 1'b1, 3'd2, 2'd3, 32'h0A);
    wr(2'd3, 8'h00);
    chk("lvl_eoi",     1'b0, 1'b0, 3'd2, 2'd3, 32'h02);
    tick();
    chk("lvl_reintr",  1'b1, 1'b0, 3'd2, 2'd3, 32'h02);
    irq = 8'h00;
    tick(); tick();
    chk("lvl_idle",    1'b0, 1'b0, 3'd2, 2'd0, 32'h0);

    // Edge-mode priority between two simultaneous requests.
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'hFF);
    irq = 8'h28;
    tick();
    chk("pri_pend",    1'b0, 1'b0, 3'd2, 2'd0, 32'h28);
    tick();
    chk("pri_intr",    1'b1, 1'b0, 3'd2, 2'd3, 32'h02);
    pulse_inta();
    chk("pri_vec3",    1'b0, 1'b1, 3'd3, 2'd3, 32'h0B);
    chk("pri_pend20",  1'b0, 1'b1, 3'd3, 2'd0, 32'h20);
    wr(2'd3, 8'h00);
    chk("pri_idle",    1'b0, 1'b0, 3'd3, 2'd0, 32'h20);
    tick();
    chk("pri_reintr",  1'b1, 1'b0, 3'd3, 2'd3, 32'h03);
    pulse_inta();
    chk("pri_vec5",    1'b0, 1'b1, 3'd5, 2'd0, 32'h0);
    wr(2'd3, 8'h00);
    chk("pri_done",    1'b0, 1'b0, 3'd5, 2'd3, 32'h05);
    irq = 8'h00;
    tick();

    // A W1C write races a new edge, then a plain W1C withdraws the request.
    irq = 8'h01;
    wr(2'd0, 8'h01);
    chk("w1c_race",    1'b0, 1'b0, 3'd5, 2'd0, 32'h01);
    wr(2'd0, 8'h01);
    chk("w1c_clr",     1'b1, 1'b0, 3'd5, 2'd0, 32'h0);
    tick();
    chk("w1c_withdraw",1'b0, 1'b0, 3'd5, 2'd3, 32'h05);
    irq = 8'h00;
    wr(2'd3, 8'h00);
    chk("sp_eoi",      1'b0, 1'b0, 3'd5, 2'd3, 32'h05);

    // A level request is withdrawn before inta arrives.
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h01);
    irq = 8'h01;
    tick(); tick();
    chk("wd_intr",     1'b1, 1'b0, 3'd5, 2'd3, 32'h05);
    irq = 8'h00;
    tick();
    chk("wd_req_hold", 1'b1, 1'b0, 3'd5, 2'd0, 32'h0);
    tick();
    chk("wd_idle",     1'b0, 1'b0, 3'd5, 2'd3, 32'h05);
    pulse_inta();
    chk("wd_late_inta",1'b0, 1'b0, 3'd5, 2'd3, 32'h05);

    // inta arrives in REQ in the same cycle that act drops to zero.
    irq = 8'h01;
    tick(); tick();
    irq = 8'h00;
    tick();
    chk("ar_req",      1'b1, 1'b0, 3'd5, 2'd0, 32'h0);
    pulse_inta();
    chk("ack_race",    1'b0, 1'b0, 3'd5, 2'd3, 32'h05);

    // A MASK write in the same cycle as inta; the pre-write mask is used.
    irq = 8'h01;
    tick(); tick();
    chk("aw_req",      1'b1, 1'b0, 3'd5, 2'd3, 32'h05);
    inta = 1'b1;
    wr(2'd1, 8'h00);
    inta = 1'b0;
    chk("ack_wr",      1'b0, 1'b1, 3'd0, 2'd1, 32'h0);
    wr(2'd3, 8'h00);
    tick();
    chk("ack_eoi",     1'b0, 1'b0, 3'd0, 2'd3, 32'h0);
    irq = 8'h00;

    // Service vector 6, check that a spurious inta is ignored, then reset.
    wr(2'd1, 8'h40);
    irq = 8'h40;
    tick(); tick();
    pulse_inta();
    chk("rst_serv",    1'b0, 1'b1, 3'd6, 2'd3, 32'h0E);
    pulse_inta();
    chk("sp_inta",     1'b0, 1'b1, 3'd6, 2'd3, 32'h0E);
    tick();
    clrn = 1'b0;
    chk("rst_async",   1'b0, 1'b0, 3'd0, 2'd1, {24'h0, RST_MASK});
    irq = 8'h00;
    tick();
    clrn = 1'b1;
    tick(); tick();
    chk("rst_after",   1'b0, 1'b0, 3'd0, 2'd0, 32'h0);

    // Give the monitor a bounded time to drain the queue.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
